// File: rtl/pentarv_pkg.sv
// pentarv_pkg: shared definitions for the pentarv five-stage core.
//   XLEN, ALUCW        default datapath / ALU-control widths
//   fwd_sel_t          Execute operand forward select encoding
//   ctrl_e_t           E-stage control bundle, CTRL_BUBBLE its all-zero bubble
//   fwd_select()       forward-select rule shared by both operands
package pentarv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALUCW = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // alu_ctrl is kept outside the struct so the ALUCW module parameter can be
  // overridden without touching this package.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

  // Memory stage has priority over Writeback; x0 never matches.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_MEM;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: combinational hazard logic around the ID/EX register.
//   valid_e, mem_read_e, rd_e   load currently held in Execute
//   valid_d, rs1_d, rs2_d       sources of the instruction in Decode
//   flush_e                     branch/jump taken in Execute
//   rs1_e, rs2_e                Execute sources (for forwarding)
//   reg_write_m/rd_m, reg_write_w/rd_w  later-stage destinations
//   lu                          load-use hazard (bubble request)
//   stall_f, stall_d, flush_d   IF/ID control
//   fwd_a, fwd_b                operand forward selects
module hazard_unit
  import pentarv_pkg::*;
(
  input  logic       valid_e,
  input  logic       mem_read_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       flush_e,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  output logic       lu,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  always_comb begin
    lu = valid_e && mem_read_e && (rd_e != 5'd0) && valid_d &&
         ((rd_e == rs1_d) || (rd_e == rs2_d));
    // A taken branch squashes the dependent instruction anyway, so no stall.
    stall_f = lu && !flush_e;
    stall_d = lu && !flush_e;
    flush_d = flush_e;
    fwd_a   = fwd_select(rs1_e, reg_write_m, rd_m, reg_write_w, rd_w);
    fwd_b   = fwd_select(rs2_e, reg_write_m, rd_m, reg_write_w, rd_w);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion,
// branch-flush squashing and Execute forward selects.
//   clk, rst                 clock, synchronous active-high reset
//   *_d                      decoded instruction, control bits, r1/r2 data
//   flush_e                  branch/jump taken in Execute
//   reg_write_m/rd_m         Memory-stage destination
//   reg_write_w/rd_w/wd_w    Writeback destination and data
//   stall_f, stall_d, flush_d  front-end hold / squash
//   *_e                      registered Execute bundle
//   fwd_a_e, fwd_b_e         operand forward selects (00 reg, 01 WB, 10 MEM)
// Optional macro ID_EX_WB_BYPASS_EN: capture wd_w in place of r1/r2 when
// Writeback targets the register being read (needed for rising-edge RF writes).
module id_ex_stage
  import pentarv_pkg::*;
#(
  parameter int unsigned XLEN  = pentarv_pkg::XLEN,
  parameter int unsigned ALUCW = pentarv_pkg::ALUCW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pcplus4_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic [XLEN-1:0]  imm_d,
  input  logic [XLEN-1:0]  r1,
  input  logic [XLEN-1:0]  r2,
  input  logic             reg_write_d,
  input  logic             mem_write_d,
  input  logic             mem_read_d,
  input  logic             alu_src_d,
  input  logic             branch_d,
  input  logic             jump_d,
  input  logic [1:0]       result_src_d,
  input  logic [ALUCW-1:0] alu_ctrl_d,
  input  logic             flush_e,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_w,
  input  logic [4:0]       rd_w,
  input  logic [XLEN-1:0]  wd_w,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             valid_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pcplus4_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic [XLEN-1:0]  imm_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic             reg_write_e,
  output logic             mem_write_e,
  output logic             mem_read_e,
  output logic             alu_src_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic [1:0]       result_src_e,
  output logic [ALUCW-1:0] alu_ctrl_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e
);

  logic             lu;
  ctrl_e_t          ctrl_d;
  ctrl_e_t          ctrl_q;
  logic [ALUCW-1:0] alu_ctrl_q;
  logic [XLEN-1:0]  rd1_d;
  logic [XLEN-1:0]  rd2_d;

  hazard_unit u_hazard (
    .valid_e     (valid_e),
    .mem_read_e  (ctrl_q.mem_read),
    .rd_e        (rd_e),
    .valid_d     (valid_d),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .flush_e     (flush_e),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .reg_write_m (reg_write_m),
    .rd_m        (rd_m),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .lu          (lu),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .fwd_a       (fwd_a_e),
    .fwd_b       (fwd_b_e)
  );

  // Control bits of a non-instruction in Decode are squashed to a bubble.
  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    if (valid_d) begin
      ctrl_d.reg_write  = reg_write_d;
      ctrl_d.mem_write  = mem_write_d;
      ctrl_d.mem_read   = mem_read_d;
      ctrl_d.alu_src    = alu_src_d;
      ctrl_d.branch     = branch_d;
      ctrl_d.jump       = jump_d;
      ctrl_d.result_src = result_src_d;
    end
  end

`ifdef ID_EX_WB_BYPASS_EN
  assign rd1_d = (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_d)) ? wd_w : r1;
  assign rd2_d = (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_d)) ? wd_w : r2;
`else
  logic unused_wd_w;
  assign unused_wd_w = ^wd_w;
  assign rd1_d = r1;
  assign rd2_d = r2;
`endif

  // Reset, flush and load-use bubble all load the same all-zero bundle.
  always_ff @(posedge clk) begin
    if (rst || flush_e || lu) begin
      valid_e    <= 1'b0;
      pc_e       <= '0;
      pcplus4_e  <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      imm_e      <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      ctrl_q     <= CTRL_BUBBLE;
      alu_ctrl_q <= '0;
    end else begin
      valid_e    <= valid_d;
      pc_e       <= pc_d;
      pcplus4_e  <= pcplus4_d;
      rs1_e      <= rs1_d;
      rs2_e      <= rs2_d;
      rd_e       <= rd_d;
      imm_e      <= imm_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= valid_d ? alu_ctrl_d : '0;
    end
  end

  assign reg_write_e  = ctrl_q.reg_write;
  assign mem_write_e  = ctrl_q.mem_write;
  assign mem_read_e   = ctrl_q.mem_read;
  assign alu_src_e    = ctrl_q.alu_src;
  assign branch_e     = ctrl_q.branch;
  assign jump_e       = ctrl_q.jump;
  assign result_src_e = ctrl_q.result_src;
  assign alu_ctrl_e   = alu_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int ALUCW = 4;
  localparam int BW    = 1 + 8*XLEN/XLEN*0 + 6*XLEN + 15 + 6 + 2 + ALUCW;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_d;
  logic [XLEN-1:0]  pc_d, pcplus4_d, imm_d, r1, r2, wd_w;
  logic [4:0]       rs1_d, rs2_d, rd_d, rd_m, rd_w;
  logic             reg_write_d, mem_write_d, mem_read_d, alu_src_d, branch_d, jump_d;
  logic [1:0]       result_src_d;
  logic [ALUCW-1:0] alu_ctrl_d;
  logic             flush_e, reg_write_m, reg_write_w;
  logic             stall_f, stall_d, flush_d, valid_e;
  logic [XLEN-1:0]  pc_e, pcplus4_e, imm_e, rd1_e, rd2_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic             reg_write_e, mem_write_e, mem_read_e, alu_src_e, branch_e, jump_e;
  logic [1:0]       result_src_e;
  logic [ALUCW-1:0] alu_ctrl_e;
  logic [1:0]       fwd_a_e, fwd_b_e;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALUCW(ALUCW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .imm_d(imm_d), .r1(r1), .r2(r2),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .mem_read_d(mem_read_d),
    .alu_src_d(alu_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .result_src_d(result_src_d), .alu_ctrl_d(alu_ctrl_d), .flush_e(flush_e),
    .reg_write_m(reg_write_m), .rd_m(rd_m), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .wd_w(wd_w), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .valid_e(valid_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .imm_e(imm_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .mem_read_e(mem_read_e),
    .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
  );

  // Reference model: the Execute-stage contents the spec says should be there.
  logic             m_valid, m_regw, m_memw, m_memr, m_alusrc, m_br, m_j;
  logic [XLEN-1:0]  m_pc, m_pc4, m_imm, m_rd1, m_rd2;
  logic [4:0]       m_rs1, m_rs2, m_rd;
  logic [1:0]       m_rsrc;
  logic [ALUCW-1:0] m_aluc;

  function automatic logic exp_lu();
    return m_valid && m_memr && (m_rd != 0) && valid_d && (m_rd == rs1_d || m_rd == rs2_d);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [XLEN-1:0] wb_pick(input logic [4:0] rs, input logic [XLEN-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (reg_write_w && rd_w != 0 && rd_w == rs) return wd_w;
`endif
    return rf;
  endfunction

  task automatic model_edge();
    if (rst || flush_e || exp_lu()) begin
      {m_valid, m_regw, m_memw, m_memr, m_alusrc, m_br, m_j} = '0;
      {m_pc, m_pc4, m_imm, m_rd1, m_rd2} = '0;
      {m_rs1, m_rs2, m_rd, m_rsrc, m_aluc} = '0;
    end else begin
      m_valid = valid_d; m_pc = pc_d; m_pc4 = pcplus4_d; m_imm = imm_d;
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      m_rd1 = wb_pick(rs1_d, r1); m_rd2 = wb_pick(rs2_d, r2);
      m_regw = valid_d & reg_write_d; m_memw = valid_d & mem_write_d;
      m_memr = valid_d & mem_read_d;  m_alusrc = valid_d & alu_src_d;
      m_br = valid_d & branch_d;      m_j = valid_d & jump_d;
      m_rsrc = valid_d ? result_src_d : 2'b00;
      m_aluc = valid_d ? alu_ctrl_d : '0;
    end
  endtask

  function automatic logic [BW-1:0] dut_bundle();
    return {valid_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e, imm_e, rd1_e, rd2_e,
            reg_write_e, mem_write_e, mem_read_e, alu_src_e, branch_e, jump_e,
            result_src_e, alu_ctrl_e};
  endfunction

  function automatic logic [BW-1:0] model_bundle();
    return {m_valid, m_pc, m_pc4, m_rs1, m_rs2, m_rd, m_imm, m_rd1, m_rd2,
            m_regw, m_memw, m_memr, m_alusrc, m_br, m_j, m_rsrc, m_aluc};
  endfunction

  // Update the model from the inputs present at the edge, then cross it.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_d = 0; pc_d = '0; pcplus4_d = '0; imm_d = '0; r1 = '0; r2 = '0; wd_w = '0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; rd_m = 0; rd_w = 0;
    reg_write_d = 0; mem_write_d = 0; mem_read_d = 0; alu_src_d = 0; branch_d = 0; jump_d = 0;
    result_src_d = 0; alu_ctrl_d = 0; flush_e = 0; reg_write_m = 0; reg_write_w = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    pc_d = 32'h1234; valid_d = 1; reg_write_d = 1; rd_d = 3;
    tick(); tick();
    n_checks++; if (dut_bundle() !== '0) $display("FAIL reset_bundle got %h want 0", dut_bundle()); else n_pass++;
    n_checks++; if ({stall_f, stall_d} !== 2'b00) $display("FAIL reset_stall got %b want 00", {stall_f, stall_d}); else n_pass++;
    n_checks++; if ({fwd_a_e, fwd_b_e} !== 4'b0) $display("FAIL reset_fwd got %b want 0000", {fwd_a_e, fwd_b_e}); else n_pass++;
    rst = 0;
  endtask

  task automatic test_plain();
    idle_inputs();
    valid_d = 1; pc_d = 32'h100; pcplus4_d = 32'h104; rd_d = 5; r1 = 32'hA;
    alu_ctrl_d = 3; rs1_d = 1; rs2_d = 2;
    #2; tick();
    n_checks++; if (pc_e !== 32'h100) $display("FAIL plain_pc got %h want 100", pc_e); else n_pass++;
    n_checks++; if (rd_e !== 5'd5) $display("FAIL plain_rd got %0d want 5", rd_e); else n_pass++;
    n_checks++; if (rd1_e !== 32'hA) $display("FAIL plain_rd1 got %h want a", rd1_e); else n_pass++;
    n_checks++; if (alu_ctrl_e !== 4'd3) $display("FAIL plain_aluctrl got %0d want 3", alu_ctrl_e); else n_pass++;
    n_checks++; if (valid_e !== 1'b1) $display("FAIL plain_valid got %b want 1", valid_e); else n_pass++;
    n_checks++; if (fwd_a_e !== 2'b00) $display("FAIL plain_fwd got %b want 00", fwd_a_e); else n_pass++;
  endtask

  task automatic test_load_use();
    idle_inputs();
    valid_d = 1; mem_read_d = 1; reg_write_d = 1; result_src_d = 2'b01; rd_d = 6; rs1_d = 2;
    #2; tick();
    mem_read_d = 0; result_src_d = 0; rs1_d = 6; rs2_d = 3; rd_d = 7;
    #2;
    n_checks++; if ({stall_f, stall_d} !== 2'b11) $display("FAIL lu_stall got %b want 11", {stall_f, stall_d}); else n_pass++;
    tick();
    n_checks++; if ({valid_e, reg_write_e, rd_e} !== 7'd0) $display("FAIL lu_bubble got v=%b rw=%b rd=%0d want 0", valid_e, reg_write_e, rd_e); else n_pass++;
    reg_write_m = 1; rd_m = 6;
    #2;
    n_checks++; if (stall_d !== 1'b0) $display("FAIL lu_stall_one_cycle got %b want 0", stall_d); else n_pass++;
    tick();
    reg_write_m = 0; rd_m = 0; reg_write_w = 1; rd_w = 6;
    #2;
    n_checks++; if (fwd_a_e !== 2'b01) $display("FAIL lu_fwd_a got %b want 01", fwd_a_e); else n_pass++;
    n_checks++; if ({valid_e, rd_e} !== {1'b1, 5'd7}) $display("FAIL lu_dep_in_e got v=%b rd=%0d want 1/7", valid_e, rd_e); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    valid_d = 1; rs1_d = 7; rs2_d = 7; rd_d = 8;
    #2; tick();
    reg_write_m = 1; rd_m = 7; reg_write_w = 1; rd_w = 7;
    #2;
    n_checks++; if ({fwd_a_e, fwd_b_e} !== 4'b1010) $display("FAIL fwd_mem_wins got %b want 1010", {fwd_a_e, fwd_b_e}); else n_pass++;
    reg_write_m = 0;
    #2;
    n_checks++; if (fwd_a_e !== 2'b01) $display("FAIL fwd_wb got %b want 01", fwd_a_e); else n_pass++;
    reg_write_m = 1; rd_m = 0; rd_w = 0;
    #2;
    n_checks++; if (fwd_a_e !== 2'b00) $display("FAIL fwd_none got %b want 00", fwd_a_e); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    valid_d = 1; mem_read_d = 1; reg_write_d = 1; rd_d = 6;
    #2; tick();
    mem_read_d = 0; rs1_d = 6; rd_d = 7; flush_e = 1;
    #2;
    n_checks++; if (flush_d !== 1'b1) $display("FAIL flush_d got %b want 1", flush_d); else n_pass++;
    n_checks++; if ({stall_f, stall_d} !== 2'b00) $display("FAIL flush_no_stall got %b want 00", {stall_f, stall_d}); else n_pass++;
    tick();
    n_checks++; if ({valid_e, reg_write_e, rd_e} !== 7'd0) $display("FAIL flush_bubble got v=%b rw=%b rd=%0d want 0", valid_e, reg_write_e, rd_e); else n_pass++;
    flush_e = 0;
  endtask

  task automatic test_x0();
    idle_inputs();
    valid_d = 1; mem_read_d = 1; reg_write_d = 1; rd_d = 0;
    #2; tick();
    mem_read_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 4;
    #2;
    n_checks++; if (stall_d !== 1'b0) $display("FAIL x0_no_stall got %b want 0", stall_d); else n_pass++;
    tick();
    n_checks++; if ({valid_e, rd_e} !== {1'b1, 5'd4}) $display("FAIL x0_advance got v=%b rd=%0d want 1/4", valid_e, rd_e); else n_pass++;
    reg_write_m = 1; rd_m = 0;
    #2;
    n_checks++; if (fwd_a_e !== 2'b00) $display("FAIL x0_no_fwd got %b want 00", fwd_a_e); else n_pass++;
  endtask

  task automatic test_reset_stall();
    idle_inputs();
    valid_d = 1; mem_read_d = 1; reg_write_d = 1; rd_d = 6; pc_d = 32'h40;
    #2; tick();
    mem_read_d = 0; rs1_d = 6; rd_d = 9;
    #2;
    n_checks++; if (stall_d !== 1'b1) $display("FAIL rststall_pre got %b want 1", stall_d); else n_pass++;
    rst = 1;
    tick();
    n_checks++; if (dut_bundle() !== '0) $display("FAIL rststall_clear got %h want 0", dut_bundle()); else n_pass++;
    n_checks++; if ({stall_f, stall_d} !== 2'b00) $display("FAIL rststall_nostall got %b want 00", {stall_f, stall_d}); else n_pass++;
    rst = 0;
  endtask

  task automatic test_wb_capture();
    logic [XLEN-1:0] want2;
`ifdef ID_EX_WB_BYPASS_EN
    want2 = 32'h55;
`else
    want2 = 32'h12;
`endif
    idle_inputs();
    valid_d = 1; rs1_d = 3; rs2_d = 9; rd_d = 2; r1 = 32'h34; r2 = 32'h12;
    reg_write_w = 1; rd_w = 9; wd_w = 32'h55;
    #2; tick();
    n_checks++; if (rd2_e !== want2) $display("FAIL wb_rd2 got %h want %h", rd2_e, want2); else n_pass++;
    n_checks++; if (rd1_e !== 32'h34) $display("FAIL wb_rd1 got %h want 34", rd1_e); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      valid_d = ($urandom_range(0, 7) != 0);
      pc_d = $urandom; pcplus4_d = pc_d + 4; imm_d = $urandom;
      r1 = $urandom; r2 = $urandom; wd_w = $urandom;
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rd_d = 5'($urandom_range(0, 3));
      rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
      {reg_write_d, mem_write_d, mem_read_d, alu_src_d, branch_d, jump_d} = 6'($urandom);
      result_src_d = 2'($urandom); alu_ctrl_d = 4'($urandom);
      #2;
      n_checks++; if ({stall_f, stall_d} !== {2{exp_lu() & ~flush_e}}) $display("FAIL rnd_stall i=%0d got %b want %b", i, {stall_f, stall_d}, {2{exp_lu() & ~flush_e}}); else n_pass++;
      n_checks++; if (flush_d !== flush_e) $display("FAIL rnd_flush_d i=%0d got %b want %b", i, flush_d, flush_e); else n_pass++;
      n_checks++; if (fwd_a_e !== exp_fwd(m_rs1)) $display("FAIL rnd_fwd_a i=%0d got %b want %b", i, fwd_a_e, exp_fwd(m_rs1)); else n_pass++;
      n_checks++; if (fwd_b_e !== exp_fwd(m_rs2)) $display("FAIL rnd_fwd_b i=%0d got %b want %b", i, fwd_b_e, exp_fwd(m_rs2)); else n_pass++;
      tick();
      n_checks++; if (dut_bundle() !== model_bundle()) $display("FAIL rnd_bundle i=%0d got %h want %h", i, dut_bundle(), model_bundle()); else n_pass++;
    end
    rst = 0; flush_e = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    {m_valid, m_regw, m_memw, m_memr, m_alusrc, m_br, m_j} = '0;
    {m_pc, m_pc4, m_imm, m_rd1, m_rd2} = '0;
    {m_rs1, m_rs2, m_rd, m_rsrc, m_aluc} = '0;
    #1;
    test_reset();
    test_plain();
    test_load_use();
    test_fwd_priority();
    test_flush();
    test_x0();
    test_reset_stall();
    test_wb_capture();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
